// File: rtl/div_fsm.sv
`default_nettype none
// ============================================================================
// Module  : div_fsm
// Brief   : Unsigned divider by repeated subtraction, serial operand load.
// Revision: 1.0
// ============================================================================
module div_fsm #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         done,
  output logic         busy,
  output logic         div_zero
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    SUB    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] q_q, q_d;
  logic         dz_q, dz_d;

  logic [W-1:0] diff;
  logic         a_lt_b;
  logic         diff_lt_b;

  // Subtraction is only committed when A>=B, so the wrap of diff is never used.
  assign diff      = a_q - b_q;
  assign a_lt_b    = (a_q < b_q);
  assign diff_lt_b = (diff < b_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_A;
      end
      LOAD_A: begin
        a_d     = data_in;
        q_d     = '0;
        dz_d    = 1'b0;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        b_d     = data_in;
        state_d = CHECK;
      end
      CHECK: begin
        if (b_q == '0) begin
          dz_d    = 1'b1;
          state_d = DONE;
        end else if (a_lt_b) begin
          state_d = DONE;
        end else begin
          state_d = SUB;
        end
      end
      SUB: begin
        a_d = diff;
        q_d = q_q + 1'b1;
        if (diff_lt_b) state_d = DONE;
      end
      DONE: begin
        // Holding start high must not retrigger; a fresh rising request is needed.
        if (!start) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign quot     = q_q;
  assign rem      = a_q;
  assign div_zero = dz_q;
  assign done     = (state_q == DONE);
  assign busy     = (state_q == LOAD_A) || (state_q == LOAD_B) ||
                    (state_q == CHECK)  || (state_q == SUB);

endmodule
`default_nettype wire
